airi5c_pcpi_dispatch: RTL

PCPI issue/response stage sitting between the core's execute stage and the PCPI coprocessor bus (custom and SIMD units). Accepts one coprocessor instruction at a time from the core, registers the instruction and operands, drives the PCPI request, and raises an illegal-instruction trap if no unit claims it within a bounded window. Turns the coprocessor's `pcpi_ready`/`pcpi_wr` response into register-file writeback pulses: one write normally, two when a 64-bit result is returned.

---
 rtl/airi5c_pcpi_dispatch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/airi5c_pcpi_dispatch.sv
// airi5c_pcpi_dispatch
//
// PCPI issue/response stage between the core's execute stage and the
// coprocessor bus. Accepts one coprocessor instruction at a time, registers
// it with its operands, drives the PCPI request and converts the
// coprocessor response into register-file writeback pulses. An instruction
// that no unit claims within TIMEOUT_CYCLES produces an illegal-instruction
// pulse instead.
//
// Optional feature macro: AIRI5C_PCPI_RD64_EN
//   defined   : pcpi_use_rd64 honoured, pcpi_rd2 written to rd+1 one cycle
//               after the first write.
//   undefined : every completion is a single writeback cycle; pcpi_use_rd64
//               and pcpi_rd2 are ignored.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   req_valid/req_ready  core request handshake: a request transfers on a
//                        rising edge where both are high (req_ready is high
//                        only in IDLE)
//   req_insn/rs1/rs2/rs3 instruction word and operands from the core
//   pcpi_valid           registered request to the coprocessors
//   pcpi_insn/rs1/rs2/rs3 registered copies of the accepted request
//   pcpi_wait/ready/wr/use_rd64, pcpi_rd/rd2  coprocessor response (OR-ed)
//   wb_valid/wb_addr/wb_data  register-file write port
//   resp_done            one-cycle pulse, instruction completed
//   resp_illegal         one-cycle pulse, instruction unclaimed
//   busy                 dispatcher not idle
//   dbg_state            current FSM state encoding

module airi5c_pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    output logic [31:0] pcpi_rs3,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    input  logic        pcpi_wr,
    input  logic        pcpi_use_rd64,
    input  logic [31:0] pcpi_rd,
    input  logic [31:0] pcpi_rd2,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        resp_done,
    output logic        resp_illegal,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB_HI = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd;

    assign rd        = pcpi_insn[11:7];
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

`ifdef AIRI5C_PCPI_RD64_EN
    logic [31:0] rd2_q;
    logic        wr_q;
    logic [4:0]  rd_hi;

    // Second destination wraps within the 5-bit register index space.
    assign rd_hi = rd + 5'd1;
`else
    logic unused_rd64;
    assign unused_rd64 = ^{pcpi_use_rd64, pcpi_rd2};
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pcpi_valid   <= 1'b0;
            pcpi_insn    <= '0;
            pcpi_rs1     <= '0;
            pcpi_rs2     <= '0;
            pcpi_rs3     <= '0;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            resp_done    <= 1'b0;
            resp_illegal <= 1'b0;
`ifdef AIRI5C_PCPI_RD64_EN
            rd2_q        <= '0;
            wr_q         <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wb_valid     <= 1'b0;
            resp_done    <= 1'b0;
            resp_illegal <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        pcpi_insn  <= req_insn;
                        pcpi_rs1   <= req_rs1;
                        pcpi_rs2   <= req_rs2;
                        pcpi_rs3   <= req_rs3;
                        cnt        <= '0;
                        pcpi_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE, S_WAIT: begin
                    // Ready takes priority over wait and over timeout expiry.
                    if (pcpi_ready) begin
                        pcpi_valid <= 1'b0;
                        if (pcpi_wr && rd != 5'd0) begin
                            wb_valid <= 1'b1;
                            wb_addr  <= rd;
                            wb_data  <= pcpi_rd;
                        end
`ifdef AIRI5C_PCPI_RD64_EN
                        rd2_q <= pcpi_rd2;
                        wr_q  <= pcpi_wr;
                        if (pcpi_use_rd64) begin
                            state <= S_WB_HI;
                        end else begin
                            resp_done <= 1'b1;
                            state     <= S_IDLE;
                        end
`else
                        resp_done <= 1'b1;
                        state     <= S_IDLE;
`endif
                    end else if (state == S_ISSUE) begin
                        // Once claimed (WAIT) the timeout no longer applies,
                        // even if pcpi_wait later drops.
                        if (pcpi_wait) begin
                            state <= S_WAIT;
                        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            pcpi_valid   <= 1'b0;
                            resp_illegal <= 1'b1;
                            state        <= S_TRAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

`ifdef AIRI5C_PCPI_RD64_EN
                S_WB_HI: begin
                    if (wr_q && rd_hi != 5'd0) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_hi;
                        wb_data  <= rd2_q;
                    end
                    resp_done <= 1'b1;
                    state     <= S_IDLE;
                end
`endif

                // resp_illegal was raised on the edge entering TRAP.
                S_TRAP: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
